// File: rtl/dmem_responder.sv
// Word-addressed data memory responder with a valid/ready request port, a programmable
// wait-state delay before each access, a one-cycle response pulse and a combinational debug peek.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    input  logic [29:0] dbg_addr,
    output logic [31:0] dbg_data
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               write_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               rsp_valid_q;
    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               access_d;
    logic               err_d;
    logic               mem_we_d;
    logic [AW-1:0]      idx_d;
    logic [31:0]        rdata_d;

    // NOTE: every signal gets a value before any condition, so no latch can be inferred.
    always_comb begin
        access_d = (state_q == S_WAIT) && (cnt_q == '0);
        err_d    = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_IDX);
        idx_d    = addr_q[AW+1:2];
        mem_we_d = access_d && write_q && !err_d;
        rdata_d  = (write_q || err_d) ? '0 : mem[idx_d];
    end

    // NOTE: the array has no reset; clearing it would turn the RAM into a huge flop bank.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem[idx_d] <= wdata_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= CNT_W'(WAIT_CYCLES);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (access_d) begin
                        rsp_rdata_q <= rdata_d;
                        rsp_err_q   <= err_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    // No backpressure: the pulse lasts exactly one cycle.
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = !req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_data  = (dbg_addr >= DEPTH_IDX) ? '0 : mem[dbg_addr[AW-1:0]];

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder: a WAIT_CYCLES=2 instance exercised against
// an array model, plus a WAIT_CYCLES=0 instance for the zero-wait latency and spacing checks.
module tb_dmem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_write, rsp_valid, rsp_err, busy;
    logic [31:0] req_addr, req_wdata, rsp_rdata, dbg_data;
    logic [29:0] dbg_addr;

    logic        req_valid0, req_ready0, req_write0, rsp_valid0, rsp_err0, busy0;
    logic [31:0] req_addr0, req_wdata0, rsp_rdata0, dbg_data0;
    logic [29:0] dbg_addr0;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model  [DEPTH];
    logic [31:0] model0 [DEPTH];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
        .req_addr(req_addr0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .busy(busy0),
        .dbg_addr(dbg_addr0), .dbg_data(dbg_data0)
    );

    function automatic logic is_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
    endfunction

    // One transaction on the W=2 instance; checks latency, ready window, pulse width and data.
    task automatic transact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          k_rsp, k_rdy, pulses;
        exp_err   = is_err(addr);
        exp_rdata = (!exp_err && !wr) ? model[addr[9:2]] : 32'h0;
        k_rsp = -1; k_rdy = -1; pulses = 0;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (rsp_valid) begin
                pulses++;
                if (k_rsp < 0) begin
                    k_rsp = k;
                    checks++;
                    if (rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
                        errors++;
                        $display("FAIL rsp_data addr=%h wr=%0b: got rdata=%h err=%b, expected rdata=%h err=%b",
                                 addr, wr, rsp_rdata, rsp_err, exp_rdata, exp_err);
                    end
                end
            end
            if (req_ready) begin
                k_rdy = k;
                break;
            end
        end
        checks++;
        if (k_rsp !== W + 1 || pulses !== 1) begin
            errors++;
            $display("FAIL rsp_latency addr=%h: got pulse at %0d (count %0d), expected at %0d (count 1)",
                     addr, k_rsp, pulses, W + 1);
        end
        checks++;
        if (k_rdy !== W + 2) begin
            errors++;
            $display("FAIL ready_window addr=%h: ready returned at %0d, expected %0d", addr, k_rdy, W + 2);
        end
        checks++;
        if (rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
            errors++;
            $display("FAIL rsp_hold addr=%h: got rdata=%h err=%b, expected rdata=%h err=%b",
                     addr, rsp_rdata, rsp_err, exp_rdata, exp_err);
        end
        if (wr && !exp_err) model[addr[9:2]] = wdata;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
            rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b valid=%b busy=%b rdata=%h err=%b, expected 1 0 0 0 0",
                     req_ready, rsp_valid, busy, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_store_load();
        transact(1'b1, 32'h10, 32'hDEAD_BEEF);
        dbg_addr = 30'd4; #1;
        checks++;
        if (dbg_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL dbg_after_store: got %h, expected %h", dbg_data, 32'hDEAD_BEEF);
        end
        transact(1'b0, 32'h10, 32'h0);
    endtask

    task automatic test_errors();
        transact(1'b1, 32'h12, 32'h1);
        dbg_addr = 30'd4; #1;
        checks++;
        if (dbg_data !== model[4]) begin
            errors++;
            $display("FAIL err_store_no_write: got %h, expected %h", dbg_data, model[4]);
        end
        transact(1'b0, 32'h400, 32'h0);
        transact(1'b0, 32'h3FF, 32'h0);
        dbg_addr = 30'd256; #1;
        checks++;
        if (dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL dbg_out_of_range: got %h, expected 0", dbg_data);
        end
    endtask

    task automatic test_hold_valid();
        logic [31:0] d1;
        int          junk[$];
        int          idx, seen;
        logic [31:0] got;
        d1 = $urandom;
        seen = 0; got = 32'h0;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = d1;
        @(posedge clk); #1;
        for (int k = 1; k <= W + 2; k++) begin
            idx = 64 + int'($urandom_range(0, 63));
            junk.push_back(idx);
            req_addr = 32'(idx) << 2; req_wdata = $urandom;
            @(posedge clk); #1;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_ready_return: got %b, expected 1", req_ready);
        end
        model[16] = d1;
        req_write = 1'b0; req_addr = 32'h40;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_next_accept: ready=%b, expected 0 right after return", req_ready);
        end
        req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin seen = 1; got = rsp_rdata; break; end
        end
        checks++;
        if (seen !== 1 || got !== d1) begin
            errors++;
            $display("FAIL hold_first_only: seen=%0d rdata=%h, expected seen=1 rdata=%h", seen, got, d1);
        end
        foreach (junk[i]) begin
            dbg_addr = 30'(junk[i]); #1;
            checks++;
            if (dbg_data !== model[junk[i]]) begin
                errors++;
                $display("FAIL hold_ignored_store idx=%0d: got %h, expected %h", junk[i], dbg_data, model[junk[i]]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0; #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_state: ready=%b busy=%b valid=%b rdata=%h, expected 1 0 0 0",
                     req_ready, busy, rsp_valid, rsp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) pulses++;
        end
        dbg_addr = 30'd8; #1;
        checks++;
        if (pulses !== 0 || dbg_data !== model[8] || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_abandon: pulses=%0d dbg=%h ready=%b, expected 0 %h 1",
                     pulses, dbg_data, req_ready, model[8]);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          sel;
        int          idx;
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      a = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
            else if (sel == 1) a = {20'h0, 10'($urandom_range(256, 1023)), 2'b00};
            else               a = {25'h0, 5'($urandom), 2'b00};
            transact(1'($urandom), a, $urandom);
        end
        for (int n = 0; n < 16; n++) begin
            idx = int'($urandom_range(0, 40));
            dbg_addr = 30'(idx); #1;
            checks++;
            if (dbg_data !== model[idx]) begin
                errors++;
                $display("FAIL dbg_peek idx=%0d: got %h, expected %h", idx, dbg_data, model[idx]);
            end
        end
    endtask

    task automatic store0(input logic [31:0] addr, input logic [31:0] wdata);
        int k_rsp;
        k_rsp = -1;
        @(negedge clk);
        req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = addr; req_wdata0 = wdata;
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk); #1;
            if (rsp_valid0) begin k_rsp = k; break; end
        end
        checks++;
        if (k_rsp !== 1) begin
            errors++;
            $display("FAIL w0_store_latency: got %0d, expected 1", k_rsp);
        end
        model0[addr[9:2]] = wdata;
        @(posedge clk); #1;
    endtask

    task automatic test_wait0();
        store0(32'h0, $urandom);
        store0(32'h4, $urandom);
        dbg_addr0 = 30'd1; #1;
        checks++;
        if (dbg_data0 !== model0[1]) begin
            errors++;
            $display("FAIL w0_dbg: got %h, expected %h", dbg_data0, model0[1]);
        end
        @(negedge clk);
        req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid0 !== 1'b1 || rsp_rdata0 !== model0[0] || rsp_err0 !== 1'b0) begin
            errors++;
            $display("FAIL w0_first_load: valid=%b rdata=%h err=%b, expected 1 %h 0",
                     rsp_valid0, rsp_rdata0, rsp_err0, model0[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL w0_ready_return: ready=%b valid=%b, expected 1 0", req_ready0, rsp_valid0);
        end
        req_addr0 = 32'h4;
        @(posedge clk); #1;
        checks++;
        if (req_ready0 !== 1'b0) begin
            errors++;
            $display("FAIL w0_second_accept: ready=%b, expected 0", req_ready0);
        end
        req_valid0 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid0 !== 1'b1 || rsp_rdata0 !== model0[1] || rsp_err0 !== 1'b0) begin
            errors++;
            $display("FAIL w0_second_load: valid=%b rdata=%h err=%b, expected 1 %h 0",
                     rsp_valid0, rsp_rdata0, rsp_err0, model0[1]);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model[i]  = 32'h0;
            model0[i] = 32'h0;
        end
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; dbg_addr = '0;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; dbg_addr0 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_store_load();
        test_errors();
        test_hold_valid();
        test_reset_mid();
        test_random();
        test_wait0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
